// File: rtl/burst_feeder.sv
// burst_feeder: buffers samples in a small FIFO, then streams the whole burst
// downstream one sample per cycle on request and waits for the downstream
// range stage to report completion, error or a timeout.
module burst_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     done_in,
    input  logic                     err_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     go_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     err_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE      = AW'(1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_FULL     = CW'(DEPTH);
    localparam logic [7:0]    TIMEOUT_LAST = 8'd254;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               go_out_q, go_out_d;
    logic               ovf_q, ovf_d;
    logic               err_out_q, err_out_d;
    logic [7:0]         timeout_q, timeout_d;
    logic               mem_we_s;
    logic               wr_ok_s;
    logic               full_s;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    assign full_s = (count_q == CNT_FULL);

    // Next-state, datapath and flag computation; clear overrides everything.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        go_out_d   = 1'b0;
        ovf_d      = ovf_q;
        err_out_d  = err_out_q;
        timeout_d  = timeout_q;
        mem_we_s   = 1'b0;
        wr_ok_s    = 1'b0;

        if (clear) begin
            state_d   = IDLE;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            go_out_d  = 1'b0;
            ovf_d     = 1'b0;
            err_out_d = 1'b0;
            timeout_d = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_ok_s = wr_en && !full_s;
                    if (wr_en && full_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (wr_ok_s) begin
                        mem_we_s = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                    if (start && ((count_q != '0) || wr_ok_s)) begin
                        // First sample is presented on the same edge that
                        // samples start; an empty buffer forwards the write.
                        state_d  = STREAM;
                        go_out_d = 1'b1;
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        count_d  = count_q + CW'(wr_ok_s) - CNT_ONE;
                        if (count_q == '0) begin
                            data_out_d = wr_data;
                        end else begin
                            data_out_d = mem_q[rd_ptr_q];
                        end
                    end else begin
                        count_d = count_q + CW'(wr_ok_s);
                    end
                end
                STREAM: begin
                    if (wr_en) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (count_q != '0) begin
                        go_out_d   = 1'b1;
                        data_out_d = mem_q[rd_ptr_q];
                        rd_ptr_d   = rd_ptr_q + PTR_ONE;
                        count_d    = count_q - CNT_ONE;
                    end else begin
                        // Burst exhausted: drop go, hold last sample.
                        go_out_d  = 1'b0;
                        state_d   = WAIT;
                        timeout_d = 8'd0;
                    end
                end
                WAIT: begin
                    if (wr_en) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    if (err_in) begin
                        err_out_d = 1'b1;
                        state_d   = IDLE;
                    end else if (done_in) begin
                        state_d = IDLE;
                    end else if (timeout_q == TIMEOUT_LAST) begin
                        err_out_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        timeout_d = timeout_q + 8'd1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    go_out_d = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            go_out_q   <= 1'b0;
            ovf_q      <= 1'b0;
            err_out_q  <= 1'b0;
            timeout_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            go_out_q   <= go_out_d;
            ovf_q      <= ovf_d;
            err_out_q  <= err_out_d;
            timeout_q  <= timeout_d;
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign data_out = data_out_q;
    assign go_out   = go_out_q;
    assign busy     = (state_q == STREAM) || (state_q == WAIT);
    assign count    = count_q;
    assign full     = full_s;
    assign empty    = (count_q == '0);
    assign ovf      = ovf_q;
    assign err_out  = err_out_q;

endmodule

// File: tb/tb_burst_feeder.sv
// Directed bench for burst_feeder: stimulus pushes the expected burst samples
// into a queue, a negedge monitor pops and compares whenever go_out is high.
module tb_burst_feeder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic             done_in = 1'b0;
    logic             err_in = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             go_out;
    logic             busy;
    logic [3:0]       count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             err_out;

    int total = 0;
    int bad = 0;
    int burst_cycles = 0;
    logic [WIDTH-1:0] exp_q [$];

    burst_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .clear(clear), .done_in(done_in), .err_in(err_in),
        .data_out(data_out), .go_out(go_out), .busy(busy), .count(count),
        .full(full), .empty(empty), .ovf(ovf), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [WIDTH-1:0] v);
        wr_en = 1'b1;
        wr_data = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_done();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Monitor: every go_out cycle must match the next expected sample.
    always @(negedge clk) begin
        if (rst_n && go_out) begin
            burst_cycles++;
            if (exp_q.size() == 0) begin
                check("unexpected_go", {24'd0, data_out}, 32'hFFFF_FFFF);
            end else begin
                check("burst_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_go", 32'(go_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {30'd0, ovf, err_out}, 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Basic 4-sample burst
        write(8'd3); write(8'd9); write(8'd1); write(8'd7);
        check("t1_count", 32'(count), 32'd4);
        exp_q.push_back(8'd3); exp_q.push_back(8'd9);
        exp_q.push_back(8'd1); exp_q.push_back(8'd7);
        burst_cycles = 0;
        pulse_start();
        check("t1_go_first", 32'(go_out), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("t1_len", 32'(burst_cycles), 32'd4);
        check("t1_go_low", 32'(go_out), 32'd0);
        check("t1_wait_busy", 32'(busy), 32'd1);
        check("t1_hold", 32'(data_out), 32'd7);
        pulse_done();
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);

        // Overfill: ninth write dropped
        for (int i = 0; i < 9; i++) write(8'(8'd16 + i));
        check("t2_full", 32'(full), 32'd1);
        check("t2_count", 32'(count), 32'd8);
        check("t2_ovf", 32'(ovf), 32'd1);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'd16 + i));
        burst_cycles = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        check("t2_len", 32'(burst_cycles), 32'd8);
        pulse_done();
        check("t2_empty", 32'(empty), 32'd1);

        // Start on empty buffer
        burst_cycles = 0;
        pulse_start();
        check("t3_no_go", 32'(go_out), 32'd0);
        check("t3_no_busy", 32'(busy), 32'd0);
        tick();
        check("t3_still_idle", {30'd0, go_out, busy}, 32'd0);
        exp_q.push_back(8'h55);
        wr_en = 1'b1; wr_data = 8'h55; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        check("t3_go", 32'(go_out), 32'd1);
        tick();
        check("t3_len", 32'(burst_cycles), 32'd1);
        check("t3_wait", {30'd0, go_out, busy}, 32'd1);
        check("t3_count", 32'(count), 32'd0);
        pulse_done();

        // WAIT timeout
        write(8'h21);
        exp_q.push_back(8'h21);
        pulse_start();
        tick();
        check("t4_in_wait", {30'd0, go_out, busy}, 32'd1);
        for (int i = 0; i < 254; i++) tick();
        check("t4_before_to", {30'd0, busy, err_out}, 32'd2);
        tick();
        check("t4_after_to", {30'd0, busy, err_out}, 32'd1);
        check("t4_ovf_sticky", 32'(ovf), 32'd1);
        pulse_clear();
        check("t4_clr_flags", {30'd0, ovf, err_out}, 32'd0);

        // err_in ignored in STREAM, honoured in WAIT
        write(8'hA1); write(8'hA2);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        pulse_start();
        err_in = 1'b1;
        tick();
        err_in = 1'b0;
        check("t5_stream_err", {30'd0, go_out, err_out}, 32'd2);
        tick();
        check("t5_wait", {29'd0, busy, go_out, err_out}, 32'd4);
        err_in = 1'b1;
        tick();
        err_in = 1'b0;
        check("t5_err_idle", {30'd0, busy, err_out}, 32'd1);
        pulse_clear();

        // Reset in the middle of a 6-sample burst
        for (int i = 0; i < 6; i++) write(8'(8'h61 + i));
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(8'h61 + i));
        pulse_start();
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_go_async", 32'(go_out), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_busy", 32'(busy), 32'd0);
        exp_q.delete();
        tick();
        burst_cycles = 0;
        rst_n = 1'b1;
        wr_en = 1'b1; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        check("t6_first_write", 32'(count), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check("t6_no_go", 32'(burst_cycles), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
